psr_cond_stage: RTL

- Pipeline stage directly downstream of the 16-bit ALU.
- Registers the ALU result and destination for register-file writeback.
- Holds the architectural processor status register (PSR), merging the ALU's 8-bit flag vector {3'b0,Z,C,F,N,L} under a per-flag write mask.
- Evaluates the 4-bit branch/jump condition code against committed flags and presents a registered taken decision to fetch.

---
 rtl/psr_cond_stage.sv | 80 ++++++++
 1 files changed

// File: rtl/psr_cond_stage.sv
// Post-ALU stage: registers writeback data, commits masked ALU flags into the
// PSR and registers the branch condition outcome evaluated against committed flags.
module psr_cond_stage #(
    parameter int WIDTH = 16,
    parameter int REGW  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [7:0]       alu_psr,
    input  logic [4:0]       flag_mask,
    input  logic             is_branch,
    input  logic [3:0]       cond,
    input  logic             rf_we_in,
    input  logic [REGW-1:0]  rf_dst_in,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] wb_result,
    output logic [REGW-1:0]  wb_dst,
    output logic             wb_we,
    output logic [7:0]       psr_q,
    output logic             branch_taken
);

    logic flag_z, flag_c, flag_f, flag_n, flag_l;
    logic cond_true;

    assign {flag_z, flag_c, flag_f, flag_n, flag_l} = psr_q[4:0];

    // Evaluated on committed flags only; no bypass from the instruction in flight.
    always_comb begin
        cond_true = 1'b0;
        unique case (cond)
            4'h0: cond_true = flag_z;
            4'h1: cond_true = ~flag_z;
            4'h2: cond_true = flag_c;
            4'h3: cond_true = ~flag_c;
            4'h4: cond_true = flag_l;
            4'h5: cond_true = ~flag_l;
            4'h6: cond_true = flag_n;
            4'h7: cond_true = ~flag_n;
            4'h8: cond_true = flag_f;
            4'h9: cond_true = ~flag_f;
            4'hA: cond_true = ~flag_l & ~flag_z;
            4'hB: cond_true = flag_l | flag_z;
            4'hC: cond_true = ~flag_n & ~flag_z;
            4'hD: cond_true = flag_n | flag_z;
            4'hE: cond_true = 1'b1;
            4'hF: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid    <= 1'b0;
            wb_result    <= '0;
            wb_dst       <= '0;
            wb_we        <= 1'b0;
            psr_q        <= 8'h00;
            branch_taken <= 1'b0;
        end else if (flush) begin
            // Data and PSR keep their values; only the qualifiers are killed.
            out_valid    <= 1'b0;
            wb_we        <= 1'b0;
            branch_taken <= 1'b0;
        end else if (!stall) begin
            out_valid    <= in_valid;
            wb_result    <= alu_result;
            wb_dst       <= rf_dst_in;
            wb_we        <= in_valid & rf_we_in & ~is_branch;
            branch_taken <= in_valid & is_branch & cond_true;
            if (in_valid && !is_branch)
                psr_q <= {3'b000, (psr_q[4:0] & ~flag_mask) | (alu_psr[4:0] & flag_mask)};
        end
    end

endmodule
